// File: rtl/ariane_pkg.sv
// Core-wide types and knobs shared between pipeline stages (slice used by the issue queue).
package ariane_pkg;

    // Depth of the decode-to-issue decoupling queue; the core top may override it.
    localparam int unsigned ISSUE_QUEUE_DEPTH = 4;

    // Decoded instruction as it travels from decode into the scoreboard.
    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  trans_id;
        logic [3:0]  fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        use_imm;
        logic        valid;
    } scoreboard_entry_t;

endpackage

// File: rtl/issue_queue_pkg.sv
// Types and helpers local to the decode-to-issue queue.
package issue_queue_pkg;

    import ariane_pkg::*;

    // One queue slot: the decoded instruction plus its control-flow marker.
    typedef struct packed {
        scoreboard_entry_t instr;
        logic              ctrl_flow;
    } iq_entry_t;

    // Number of accepted enqueue slots in a cycle (0, 1 or 2).
    function automatic logic [1:0] ack_count(input logic [1:0] ack);
        return {1'b0, ack[0]} + {1'b0, ack[1]};
    endfunction

endpackage

// File: rtl/issue_queue_checker.sv
// Protocol and configuration checks for the issue queue; no functional logic.
module issue_queue_checker #(
    parameter int unsigned NR_ENQ_PORTS = 2
) (
    input logic       clk_i,
    input logic       rst_ni,
    input logic [1:0] instr_valid_i
);

    // The enqueue path is hard-wired for exactly two decode slots.
    if (NR_ENQ_PORTS != 2) begin : g_bad_enq_ports
        $error("issue_queue: NR_ENQ_PORTS must be 2");
    end

    // Decode must present slot 0 whenever slot 1 is valid, otherwise order breaks.
    slot1_without_slot0 : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(instr_valid_i[1] && !instr_valid_i[0])
    ) else $error("issue_queue: slot 1 valid without slot 0");

endmodule

// File: rtl/issue_queue.sv
// Decode-to-issue decoupling queue: two in-order enqueue slots, one issue slot,
// control-flow gating while a dispatched branch is unresolved, full clear on flush.
module issue_queue
    import ariane_pkg::*;
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = ISSUE_QUEUE_DEPTH,
    parameter int unsigned NR_ENQ_PORTS = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  scoreboard_entry_t [1:0]       instr_i,
    input  logic [1:0]                    instr_valid_i,
    input  logic [1:0]                    is_ctrl_flow_i,
    output logic [1:0]                    instr_ack_o,
    output scoreboard_entry_t             decoded_instr_o,
    output logic                          decoded_instr_valid_o,
    output logic                          is_ctrl_flow_o,
    input  logic                          decoded_instr_ack_i,
    input  logic                          resolve_branch_i,
    output logic [$clog2(DEPTH+1)-1:0]    usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    // Occupancy limits for accepting one or two new entries.
    localparam logic [CNT_W-1:0] ROOM_ONE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ROOM_TWO = CNT_W'(DEPTH - 2);

    iq_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]   wr_ptr_p1_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic               branch_pending_r, branch_pending_s;
    logic [1:0]         ack_s;
    logic [1:0]         n_enq_s;
    iq_entry_t          head_s;
    logic               head_valid_s;
    logic               pop_s;

    // Enqueue acceptance from registered occupancy only; slot 1 rides on slot 0.
    always_comb begin
        ack_s = 2'b00;
        if (rst_ni && !flush_i && instr_valid_i[0] && (count_r <= ROOM_ONE)) begin
            ack_s[0] = 1'b1;
            ack_s[1] = instr_valid_i[1] && (count_r <= ROOM_TWO);
        end else begin
            ack_s = 2'b00;
        end
    end

    // Head presentation; an empty queue shows an all-zero entry.
    always_comb begin
        head_s       = {$bits(iq_entry_t){1'b0}};
        head_valid_s = 1'b0;
        if (count_r != {CNT_W{1'b0}}) begin
            head_s       = mem_r[rd_ptr_r];
            head_valid_s = !flush_i && !(branch_pending_r && head_s.ctrl_flow);
        end else begin
            head_s       = {$bits(iq_entry_t){1'b0}};
            head_valid_s = 1'b0;
        end
    end

    assign n_enq_s     = ack_count(ack_s);
    assign pop_s       = head_valid_s && decoded_instr_ack_i;
    assign wr_ptr_p1_s = wr_ptr_r + PTR_W'(1'b1);

    assign instr_ack_o           = ack_s;
    assign decoded_instr_o       = head_s.instr;
    assign is_ctrl_flow_o        = head_s.ctrl_flow;
    assign decoded_instr_valid_o = head_valid_s;
    assign usage_o               = count_r;

    // Next pointers, occupancy and branch gate; flush overrides all traffic.
    always_comb begin
        rd_ptr_s         = rd_ptr_r;
        wr_ptr_s         = wr_ptr_r;
        count_s          = count_r;
        branch_pending_s = branch_pending_r;
        if (flush_i) begin
            rd_ptr_s         = {PTR_W{1'b0}};
            wr_ptr_s         = {PTR_W{1'b0}};
            count_s          = {CNT_W{1'b0}};
            branch_pending_s = 1'b0;
        end else begin
            rd_ptr_s = rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_s = wr_ptr_r + PTR_W'(n_enq_s);
            count_s  = count_r + CNT_W'(n_enq_s) - CNT_W'(pop_s);
            // Dispatching a branch wins over a resolve, which belongs to the older one.
            if (pop_s && head_s.ctrl_flow) begin
                branch_pending_s = 1'b1;
            end else if (resolve_branch_i) begin
                branch_pending_s = 1'b0;
            end else begin
                branch_pending_s = branch_pending_r;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r         <= {PTR_W{1'b0}};
            wr_ptr_r         <= {PTR_W{1'b0}};
            count_r          <= {CNT_W{1'b0}};
            branch_pending_r <= 1'b0;
        end else begin
            rd_ptr_r         <= rd_ptr_s;
            wr_ptr_r         <= wr_ptr_s;
            count_r          <= count_s;
            branch_pending_r <= branch_pending_s;
        end
    end

    // Entry storage; contents are only meaningful below count_r, so no reset.
    always_ff @(posedge clk_i) begin
        if (ack_s[0]) begin
            mem_r[wr_ptr_r] <= '{instr: instr_i[0], ctrl_flow: is_ctrl_flow_i[0]};
        end
        if (ack_s[1]) begin
            mem_r[wr_ptr_p1_s] <= '{instr: instr_i[1], ctrl_flow: is_ctrl_flow_i[1]};
        end
    end

    issue_queue_checker #(
        .NR_ENQ_PORTS (NR_ENQ_PORTS)
    ) u_checker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_valid_i (instr_valid_i)
    );

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue (DEPTH = 4) with hand-computed expectations.
module tb_issue_queue;
    import ariane_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    scoreboard_entry_t [1:0] instr;
    logic [1:0]              instr_valid;
    logic [1:0]              is_cf_in;
    logic [1:0]              instr_ack;
    scoreboard_entry_t       dec_instr;
    logic                    dec_valid;
    logic                    is_cf_out;
    logic                    dec_ack;
    logic                    resolve;
    logic [2:0]              usage;

    int n_checks = 0;
    int n_errors = 0;

    issue_queue #(.DEPTH(4), .NR_ENQ_PORTS(2)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .instr_i               (instr),
        .instr_valid_i         (instr_valid),
        .is_ctrl_flow_i        (is_cf_in),
        .instr_ack_o           (instr_ack),
        .decoded_instr_o       (dec_instr),
        .decoded_instr_valid_o (dec_valid),
        .is_ctrl_flow_o        (is_cf_out),
        .decoded_instr_ack_i   (dec_ack),
        .resolve_branch_i      (resolve),
        .usage_o               (usage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic scoreboard_entry_t mk(input logic [63:0] pc);
        scoreboard_entry_t e;
        e    = '0;
        e.pc = pc;
        return e;
    endfunction

    // Apply one cycle of inputs just after the falling edge, then let them settle.
    task automatic drive(input logic [1:0] v, input logic [1:0] cf,
                         input logic [63:0] pc0, input logic [63:0] pc1,
                         input logic ack, input logic res, input logic fl);
        @(negedge clk);
        instr_valid = v;
        is_cf_in    = cf;
        instr[0]    = mk(pc0);
        instr[1]    = mk(pc1);
        dec_ack     = ack;
        resolve     = res;
        flush       = fl;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        instr       = '0;
        instr_valid = 2'b00;
        is_cf_in    = 2'b00;
        dec_ack     = 1'b0;
        resolve     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_usage", 64'(usage), 64'd0);
        check_eq("rst_valid", 64'(dec_valid), 64'd0);
        check_eq("rst_cf", 64'(is_cf_out), 64'd0);
        check_eq("rst_instr_zero", 64'(dec_instr == '0), 64'd1);
        rst_n = 1'b1;

        // Two instructions in one cycle, then issue them back to back.
        drive(2'b11, 2'b00, 64'h100, 64'h104, 1'b1, 1'b0, 1'b0);
        check_eq("t1_ack", 64'(instr_ack), 64'd3);
        check_eq("t1_no_bypass", 64'(dec_valid), 64'd0);
        check_eq("t1_usage0", 64'(usage), 64'd0);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t1_valid_a", 64'(dec_valid), 64'd1);
        check_eq("t1_pc_a", dec_instr.pc, 64'h100);
        check_eq("t1_usage2", 64'(usage), 64'd2);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t1_pc_b", dec_instr.pc, 64'h104);
        check_eq("t1_usage1", 64'(usage), 64'd1);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_usage_end", 64'(usage), 64'd0);
        check_eq("t1_empty", 64'(dec_valid), 64'd0);

        // Fill to full, then partial acceptance at count 3.
        drive(2'b11, 2'b00, 64'h200, 64'h204, 1'b0, 1'b0, 1'b0);
        check_eq("t2_ack_a", 64'(instr_ack), 64'd3);
        drive(2'b11, 2'b00, 64'h208, 64'h20C, 1'b0, 1'b0, 1'b0);
        check_eq("t2_ack_b", 64'(instr_ack), 64'd3);
        drive(2'b11, 2'b00, 64'h210, 64'h214, 1'b0, 1'b0, 1'b0);
        check_eq("t2_full_usage", 64'(usage), 64'd4);
        check_eq("t2_full_ack", 64'(instr_ack), 64'd0);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_pop_pc", dec_instr.pc, 64'h200);
        drive(2'b11, 2'b00, 64'h300, 64'h304, 1'b0, 1'b0, 1'b0);
        check_eq("t2_cnt3_usage", 64'(usage), 64'd3);
        check_eq("t2_cnt3_ack", 64'(instr_ack), 64'd1);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_pc_204", dec_instr.pc, 64'h204);
        drive(2'b11, 2'b00, 64'h400, 64'h404, 1'b1, 1'b0, 1'b0);
        check_eq("t2_pop_ack", 64'(instr_ack), 64'd1);
        check_eq("t2_pc_208", dec_instr.pc, 64'h208);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_usage_stay3", 64'(usage), 64'd3);
        check_eq("t2_pc_20c", dec_instr.pc, 64'h20C);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_pc_300", dec_instr.pc, 64'h300);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_pc_400", dec_instr.pc, 64'h400);

        // Branch gating: branch, plain op, branch.
        drive(2'b11, 2'b01, 64'h500, 64'h504, 1'b0, 1'b0, 1'b0);
        check_eq("t3_usage0", 64'(usage), 64'd0);
        check_eq("t3_ack", 64'(instr_ack), 64'd3);
        drive(2'b01, 2'b01, 64'h508, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_br1_valid", 64'(dec_valid), 64'd1);
        check_eq("t3_br1_cf", 64'(is_cf_out), 64'd1);
        check_eq("t3_br1_pc", dec_instr.pc, 64'h500);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_plain_valid", 64'(dec_valid), 64'd1);
        check_eq("t3_plain_pc", dec_instr.pc, 64'h504);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_br2_blocked", 64'(dec_valid), 64'd0);
        check_eq("t3_br2_cf", 64'(is_cf_out), 64'd1);
        check_eq("t3_usage1", 64'(usage), 64'd1);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        check_eq("t3_resolve_cycle", 64'(dec_valid), 64'd0);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_br2_released", 64'(dec_valid), 64'd1);
        check_eq("t3_br2_pc", dec_instr.pc, 64'h508);

        // Pop of a branch coincident with a resolve keeps the gate set.
        drive(2'b11, 2'b11, 64'h600, 64'h604, 1'b0, 1'b1, 1'b0);
        check_eq("t4_ack", 64'(instr_ack), 64'd3);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        check_eq("t4_br_valid", 64'(dec_valid), 64'd1);
        check_eq("t4_br_pc", dec_instr.pc, 64'h600);
        drive(2'b11, 2'b10, 64'h700, 64'h704, 1'b0, 1'b0, 1'b0);
        check_eq("t4_set_wins", 64'(dec_valid), 64'd0);
        check_eq("t4_usage1", 64'(usage), 64'd1);
        check_eq("t4_ack2", 64'(instr_ack), 64'd3);

        // Flush with count 3, branch pending and live inputs.
        drive(2'b11, 2'b00, 64'h710, 64'h714, 1'b1, 1'b0, 1'b1);
        check_eq("t5_usage3", 64'(usage), 64'd3);
        check_eq("t5_flush_ack", 64'(instr_ack), 64'd0);
        check_eq("t5_flush_valid", 64'(dec_valid), 64'd0);
        drive(2'b01, 2'b01, 64'h800, 64'h0, 1'b0, 1'b0, 1'b0);
        check_eq("t5_usage0", 64'(usage), 64'd0);
        check_eq("t5_ack", 64'(instr_ack), 64'd1);
        check_eq("t5_no_bypass", 64'(dec_valid), 64'd0);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_eq("t5_pending_clear", 64'(dec_valid), 64'd1);
        check_eq("t5_pc", dec_instr.pc, 64'h800);
        drive(2'b00, 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        check_eq("t5_usage_end", 64'(usage), 64'd0);

        // Twelve overlapped enqueue/dequeue pairs across three pointer wraps.
        for (int i = 0; i <= 12; i++) begin
            drive((i < 12) ? 2'b01 : 2'b00, 2'b00, 64'h900 + 64'(4 * i), 64'h0,
                  (i > 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (i < 12) check_eq("t6_ack", 64'(instr_ack), 64'd1);
            if (i > 0) begin
                check_eq("t6_valid", 64'(dec_valid), 64'd1);
                check_eq("t6_order", dec_instr.pc, 64'h900 + 64'(4 * (i - 1)));
                check_eq("t6_usage", 64'(usage), 64'd1);
            end
        end

        // Asynchronous reset in the middle of traffic.
        drive(2'b11, 2'b11, 64'hA00, 64'hA04, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 2'b00, 64'hA08, 64'hA0C, 1'b1, 1'b0, 1'b0);
        check_eq("t7_usage2", 64'(usage), 64'd2);
        check_eq("t7_ack", 64'(instr_ack), 64'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t7_rst_usage", 64'(usage), 64'd0);
        check_eq("t7_rst_valid", 64'(dec_valid), 64'd0);
        check_eq("t7_rst_ack", 64'(instr_ack), 64'd0);
        check_eq("t7_rst_cf", 64'(is_cf_out), 64'd0);
        check_eq("t7_rst_instr_zero", 64'(dec_instr == '0), 64'd1);
        instr_valid = 2'b00;
        dec_ack     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
Decoupling queue between the decode stage and the issue stage. It accepts up to two decoded instructions per cycle, in program order, and stores them in a circular buffer. It presents one instruction per cycle to the issue stage's decoded-instruction valid/ack interface. It holds back a control-flow instruction while a previously dispatched branch is still unresolved, and clears completely on flush.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
NR_ENQ_PORTS, 2, enqueue ports; fixed at 2, and the RTL asserts this at elaboration.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
flush_i  input  1  discard all entries and clear the branch-pending state
instr_i  input  [1:0] scoreboard_entry_t  decoded instructions; slot 0 is older
instr_valid_i  input  2  per-slot valid
is_ctrl_flow_i  input  2  per-slot: instruction is a branch or jump
instr_ack_o  output  2  per-slot accept, combinational
decoded_instr_o  output  scoreboard_entry_t  head entry
decoded_instr_valid_o  output  1  head is valid and issuable
is_ctrl_flow_o  output  1  head is control flow
decoded_instr_ack_i  input  1  issue stage consumed the head
resolve_branch_i  input  1  execute stage resolved the pending branch
usage_o  output  $clog2(DEPTH+1)  registered occupancy

Behaviour:
- State:
  - mem[DEPTH]: each entry holds {scoreboard_entry_t, ctrl_flow bit}.
  - rd_ptr_q and wr_ptr_q: $clog2(DEPTH) bits each; they wrap naturally modulo DEPTH.
  - count_q: $clog2(DEPTH+1) bits.
  - branch_pending_q: 1 bit.
- Reset: all pointers, count_q and branch_pending_q go to 0. All outputs are 0 and decoded_instr_o is all-zero. mem contents are don't-care.
- Enqueue (uses registered occupancy only; no credit from a same-cycle dequeue):
  - instr_ack_o[0] = instr_valid_i[0] && !flush_i && count_q <= DEPTH-1.
  - instr_ack_o[1] = instr_valid_i[1] && instr_ack_o[0] && count_q <= DEPTH-2.
  - Slot 1 is never accepted without slot 0 (preserves order). instr_valid_i[1] with !instr_valid_i[0] is illegal; the RTL asserts on it and does not ack it.
  - Slot 0 is written at wr_ptr_q, slot 1 at wr_ptr_q+1 (mod DEPTH).
  - wr_ptr_q advances by the number of acks.
- Dequeue:
  - decoded_instr_o = mem[rd_ptr_q]; is_ctrl_flow_o = ctrl_flow bit of the head.
  - decoded_instr_valid_o = count_q != 0 && !flush_i && !(branch_pending_q && is_ctrl_flow_o).
  - A pop occurs when decoded_instr_valid_o && decoded_instr_ack_i. rd_ptr_q then advances by 1.
  - decoded_instr_ack_i while valid is low is ignored.
  - Once raised, valid stays high with a stable head until the ack, except on flush.
- Latency: an instruction enqueued in cycle N is visible at the head no earlier than N+1. There is no bypass, so an empty queue with valid input gives valid_o=0 in that cycle.
- count_q: next = count_q + (number of acked slots) − pop. The simultaneous 2-enqueue plus 1-pop case nets +1.
- Branch gating (branch_pending_q):
  - Set when a pop occurs and is_ctrl_flow_o=1.
  - Otherwise cleared when resolve_branch_i=1.
  - If a set and a clear happen in the same cycle, set wins: the resolve belongs to the older branch.
  - Non-control-flow instructions issue freely while a branch is pending.
  - If resolve_branch_i arrives while a control-flow head is blocked, the head becomes valid the next cycle.
- Flush:
  - In the flush cycle, acks and valid_o are forced to 0.
  - Next cycle: rd_ptr_q = wr_ptr_q = 0, count_q = 0, branch_pending_q = 0.
  - Flush has priority over every other event in the same cycle.
- Reset mid-operation: asynchronous clear to the reset state, regardless of traffic.
- Full: count_q == DEPTH gives instr_ack_o = 00.
- Empty: count_q == 0 gives valid_o = 0.
- usage_o = count_q.

Decomposition:
- Reuse scoreboard_entry_t from ariane_pkg.
- Add ISSUE_QUEUE_DEPTH (default 4) to ariane_pkg so the core top can override the depth.
- No sub-module: storage, pointers and gating fit in one module (~180 lines).

Test Plan:
- Reset, then write 2 instrs (pc 0x100, 0x104) in one cycle with ack held 1 → ack_o=11 in cycle 0; valid_o=1 from cycle 1; pc 0x100 then 0x104 on consecutive cycles; usage_o 0→2→1→0.
- Fill to DEPTH=4, then offer 2 → ack_o=00. At count 3, offer 2 → ack_o=01b (slot 0 only). At count 3 with a pop and 2 offered → ack_o=01b and count stays 3.
- Branch at head popped, next head also a branch → valid_o=0 until resolve_branch_i pulses; valid_o=1 the following cycle. A non-branch between the two issues without stalling.
- Same cycle: pop a branch and assert resolve_branch_i → branch_pending_q=1 next cycle; the next branch head is blocked.
- flush_i with count=3, branch_pending=1 and valid inputs present → ack_o=00 and valid_o=0 that cycle; count=0 and pending=0 next cycle; a new instr issues 1 cycle after enqueue.
- Wrap-around: 12 single enqueue/dequeue pairs with DEPTH=4 → strict program order preserved across 3 pointer wraps; rst_ni asserted mid-stream → all outputs 0 immediately.
